// File: rtl/ac_pkg.sv
// Shared widths, opcode and FSM state encodings for the ac_core accumulator CPU.
package ac_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = DATA_W - ADDR_W;

  localparam logic [OP_W-1:0] OP_LDA = 3'd0;
  localparam logic [OP_W-1:0] OP_STA = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_JMP = 3'd4;
  localparam logic [OP_W-1:0] OP_JZ  = 3'd5;
  localparam logic [OP_W-1:0] OP_JC  = 3'd6;
  localparam logic [OP_W-1:0] OP_HLT = 3'd7;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/ac_alu.sv
// Shared add/subtract datapath; subtraction reuses the adder as a + ~b + 1.
module ac_alu
  import ac_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] y_o,
  output logic              c_o,
  output logic              z_o
);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;

  always_comb begin
    b_op = sub_i ? ~b_i : b_i;
    sum  = {1'b0, a_i} + {1'b0, b_op} + (DATA_W+1)'(sub_i);
    y_o  = sum[DATA_W-1:0];
    // Borrow is the inverted carry-out of the complemented add.
    c_o  = sub_i ? ~sum[DATA_W] : sum[DATA_W];
    z_o  = (y_o == '0);
  end

endmodule

// File: rtl/ac_core.sv
// Accumulator CPU: FETCH/EXEC FSM with terminal HALT, sole master of a 32x8 RAM.
module ac_core
  import ac_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wen_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              zero_o,
  output logic              carry_o,
  output logic              halted_o
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c, alu_z;

  assign opcode  = ir_q[DATA_W-1 -: OP_W];
  assign operand = ir_q[ADDR_W-1:0];

  ac_alu u_alu (
    .a_i   (acc_q),
    .b_i   (ram_dout_i),
    .sub_i (opcode == OP_SUB),
    .y_o   (alu_y),
    .c_o   (alu_c),
    .z_o   (alu_z)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Next-state and instruction execution.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      ST_FETCH: begin
        if (run_i) begin
          ir_d    = ram_dout_i;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_LDA: begin
            acc_d = ram_dout_i;
            z_d   = (ram_dout_i == '0);
          end
          OP_ADD, OP_SUB: begin
            acc_d = alu_y;
            z_d   = alu_z;
            c_d   = alu_c;
          end
          OP_JMP: pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_HLT: state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // RAM port: operand address only while executing, otherwise the PC.
  assign ram_addr_o = (state_q == ST_EXEC) ? operand : pc_q;
  assign ram_wen_o  = (state_q == ST_EXEC) && (opcode == OP_STA);
  assign ram_din_o  = acc_q;

  assign acc_o    = acc_q;
  assign pc_o     = pc_q;
  assign zero_o   = z_q;
  assign carry_o  = c_q;
  assign halted_o = (state_q == ST_HALT);

endmodule

// File: tb/tb_ac_core.sv
// Directed bench for ac_core with a behavioural 32x8 RAM and an expectation queue.
module tb_ac_core;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] ram_dout;
  logic [4:0] ram_addr;
  logic       ram_wen;
  logic [7:0] ram_din;
  logic [7:0] acc;
  logic [4:0] pc;
  logic       zero;
  logic       carry;
  logic       halted;

  logic [7:0] mem [32];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wen_cnt = 0;
  logic [4:0] wen_addr = '0;

  ac_core dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .run_i      (run),
    .ram_dout_i (ram_dout),
    .ram_addr_o (ram_addr),
    .ram_wen_o  (ram_wen),
    .ram_din_o  (ram_din),
    .acc_o      (acc),
    .pc_o       (pc),
    .zero_o     (zero),
    .carry_o    (carry),
    .halted_o   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_wen) mem[ram_addr] <= ram_din;

  always @(negedge clk) begin
    if (ram_wen) begin
      wen_cnt  = wen_cnt + 1;
      wen_addr = ram_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h expected <none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    tick(1);
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    wen_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    #1;

    // Reset, run low: everything at reset values for 5 cycles
    for (int i = 0; i < 5; i++) begin
      exp("rst_pc", 0); exp("rst_acc", 0); exp("rst_addr", 0);
      exp("rst_wen", 0); exp("rst_halt", 0);
      tick(1);
      chk(pc); chk(acc); chk(ram_addr); chk(ram_wen); chk(halted);
    end

    // LDA 30, ADD 31, STA 29, HLT
    mem[0] = 8'h1E; mem[1] = 8'h5F; mem[2] = 8'h3D; mem[3] = 8'hE0;
    mem[30] = 8'h03; mem[31] = 8'h02;
    rst_n = 1'b1;
    run   = 1'b1;
    exp("p1_m29", 8'h05); exp("p1_acc", 8'h05); exp("p1_c", 0); exp("p1_z", 0);
    exp("p1_halt", 1); exp("p1_pc", 4); exp("p1_wen_cnt", 1); exp("p1_wen_addr", 29);
    tick(8);
    chk(mem[29]); chk(acc); chk(carry); chk(zero);
    chk(halted); chk(pc); chk(wen_cnt); chk(wen_addr);
    exp("p1_halt_hold", 1); exp("p1_pc_hold", 4);
    tick(3);
    chk(halted); chk(pc);

    // Carry/zero then taken JC: LDA 20, ADD 21, JC 10; M[10]=HLT
    start_reset();
    mem[0] = 8'h14; mem[1] = 8'h55; mem[2] = 8'hCA; mem[10] = 8'hE0;
    mem[20] = 8'hFF; mem[21] = 8'h01;
    rst_n = 1'b1;
    run   = 1'b1;
    exp("p2_acc", 8'h00); exp("p2_z", 1); exp("p2_c", 1);
    tick(4);
    chk(acc); chk(zero); chk(carry);
    exp("p2_pc_jc", 10); exp("p2_halt0", 0);
    tick(2);
    chk(pc); chk(halted);
    exp("p2_halt", 1); exp("p2_pc_hlt", 11);
    tick(2);
    chk(halted); chk(pc);

    // Borrow then not-taken JZ: LDA 20, SUB 21, JZ 10, HLT
    start_reset();
    mem[0] = 8'h14; mem[1] = 8'h75; mem[2] = 8'hAA; mem[3] = 8'hE0;
    mem[20] = 8'h02; mem[21] = 8'h03;
    rst_n = 1'b1;
    run   = 1'b1;
    exp("p3_acc", 8'hFF); exp("p3_c", 1); exp("p3_z", 0);
    tick(4);
    chk(acc); chk(carry); chk(zero);
    exp("p3_pc_jz", 3);
    tick(2);
    chk(pc);
    exp("p3_halt", 1); exp("p3_pc_hlt", 4);
    tick(2);
    chk(halted); chk(pc);

    // PC wrap and stall: JMP 31; M[31]=LDA 30
    start_reset();
    mem[0] = 8'h9F; mem[31] = 8'h1E; mem[30] = 8'h42;
    rst_n = 1'b1;
    run   = 1'b1;
    exp("p4_pc_jmp", 31);
    tick(2);
    chk(pc);
    exp("p4_pc_wrap", 0); exp("p4_addr_exec", 30);
    tick(1);
    chk(pc); chk(ram_addr);
    run = 1'b0;
    exp("p4_acc", 8'h42); exp("p4_pc_done", 0);
    tick(1);
    chk(acc); chk(pc);
    for (int i = 0; i < 4; i++) begin
      exp("p4_stall_pc", 0); exp("p4_stall_acc", 8'h42); exp("p4_stall_addr", 0);
      tick(1);
      chk(pc); chk(acc); chk(ram_addr);
    end

    // Reset during STA EXEC: LDA 20, STA 25, HLT
    start_reset();
    mem[0] = 8'h14; mem[1] = 8'h39; mem[2] = 8'hE0;
    mem[20] = 8'h77; mem[25] = 8'h11;
    rst_n = 1'b1;
    run   = 1'b1;
    exp("p5_wen_pre", 1); exp("p5_addr_pre", 25);
    tick(3);
    chk(ram_wen); chk(ram_addr);
    rst_n = 1'b0;
    exp("p5_wen_rst", 0); exp("p5_pc_rst", 0); exp("p5_acc_rst", 0);
    exp("p5_addr_rst", 0); exp("p5_z_rst", 0); exp("p5_c_rst", 0);
    #1;
    chk(ram_wen); chk(pc); chk(acc); chk(ram_addr); chk(zero); chk(carry);
    exp("p5_m25_kept", 8'h11); exp("p5_wen_cnt", 0);
    tick(1);
    chk(mem[25]); chk(wen_cnt);
    rst_n = 1'b1;
    exp("p5_pc_restart", 1);
    tick(1);
    chk(pc);
    exp("p5_acc_restart", 8'h77);
    tick(1);
    chk(acc);
    exp("p5_m25_new", 8'h77); exp("p5_halt", 1); exp("p5_pc_hlt", 3);
    tick(4);
    chk(mem[25]); chk(halted); chk(pc);

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: observed %0d expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
